// File: rtl/armleocpu_csr_exec_pkg.sv
// Shared encodings for the Zicsr execute sequencer: CSR file command codes,
// funct3 operation classes and the sequencer FSM states.
package armleocpu_csr_exec_pkg;

    localparam int CSR_CMD_WIDTH = 4;

    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CMD_NONE       = 4'd0;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CMD_READ       = 4'd1;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CMD_WRITE      = 4'd2;
    localparam logic [CSR_CMD_WIDTH-1:0] CSR_CMD_READ_WRITE = 4'd3;

    // funct3[1:0] selects the operation; funct3[2] only selects zimm vs rs1.
    localparam logic [1:0] F3_ILLEGAL = 2'b00;
    localparam logic [1:0] F3_RW      = 2'b01;
    localparam logic [1:0] F3_RS      = 2'b10;
    localparam logic [1:0] F3_RC      = 2'b11;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_ACCESS = 2'd1,
        STATE_WRITE  = 2'd2,
        STATE_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/armleocpu_csr_exec.sv
// Splits one Zicsr instruction into READ / WRITE / READ_WRITE commands for the
// CSR file, merges set/clear forms and returns the old value to writeback.
module armleocpu_csr_exec
    import armleocpu_csr_exec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_funct3,
    input  logic [11:0]              req_address,
    input  logic [31:0]              req_rs1_data,
    input  logic [4:0]               req_zimm,
    input  logic                     req_rs1_is_x0,
    input  logic                     req_rd_is_x0,

    input  logic                     kill,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rd_data,
    output logic                     rsp_rd_write,
    output logic                     rsp_invalid,

    output logic [CSR_CMD_WIDTH-1:0] csr_cmd,
    output logic [11:0]              csr_address,
    output logic [31:0]              csr_writedata,
    input  logic [31:0]              csr_readdata,
    input  logic                     csr_invalid
);

    state_t      state;
    state_t      state_next;
    logic [11:0] address;
    logic [1:0]  op;
    logic        rs1_is_x0;
    logic        rd_is_x0;
    logic [31:0] operand;
    logic [31:0] old_value;
    logic        invalid;
    logic        accept;

    assign accept      = (state == STATE_IDLE) && req_valid && !kill;
    assign csr_address = address;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= STATE_IDLE;
            address   <= '0;
            op        <= '0;
            rs1_is_x0 <= 1'b0;
            rd_is_x0  <= 1'b0;
            operand   <= '0;
            old_value <= '0;
            invalid   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                address   <= req_address;
                op        <= req_funct3[1:0];
                rs1_is_x0 <= req_rs1_is_x0;
                rd_is_x0  <= req_rd_is_x0;
                operand   <= req_funct3[2] ? {27'd0, req_zimm} : req_rs1_data;
                old_value <= '0;
                invalid   <= (req_funct3[1:0] == F3_ILLEGAL);
            end else if (state == STATE_ACCESS && !kill) begin
                old_value <= csr_readdata;
                invalid   <= csr_invalid;
            end else if (state == STATE_WRITE && !kill) begin
                // A read-only CSR only reports itself on the write attempt.
                invalid   <= invalid | csr_invalid;
            end
        end
    end

    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rd_data   = '0;
        rsp_rd_write  = 1'b0;
        rsp_invalid   = 1'b0;
        csr_cmd       = CSR_CMD_NONE;
        csr_writedata = '0;
        case (state)
            STATE_IDLE: begin
                req_ready = !kill;
                if (accept) begin
                    state_next = (req_funct3[1:0] == F3_ILLEGAL) ? STATE_RESP : STATE_ACCESS;
                end
            end
            STATE_ACCESS: begin
                if (op == F3_RW) begin
                    csr_cmd       = rd_is_x0 ? CSR_CMD_WRITE : CSR_CMD_READ_WRITE;
                    csr_writedata = operand;
                end else begin
                    csr_cmd = CSR_CMD_READ;
                end
                if (kill) begin
                    csr_cmd    = CSR_CMD_NONE;
                    state_next = STATE_IDLE;
                end else if (csr_invalid || op == F3_RW || rs1_is_x0) begin
                    state_next = STATE_RESP;
                end else begin
                    state_next = STATE_WRITE;
                end
            end
            STATE_WRITE: begin
                csr_cmd       = CSR_CMD_WRITE;
                csr_writedata = (op == F3_RS) ? (old_value | operand) : (old_value & ~operand);
                if (kill) begin
                    csr_cmd    = CSR_CMD_NONE;
                    state_next = STATE_IDLE;
                end else begin
                    state_next = STATE_RESP;
                end
            end
            STATE_RESP: begin
                if (kill) begin
                    state_next = STATE_IDLE;
                end else begin
                    rsp_valid    = 1'b1;
                    rsp_rd_data  = invalid ? 32'd0 : old_value;
                    rsp_rd_write = !invalid && !rd_is_x0;
                    rsp_invalid  = invalid;
                    if (rsp_ready) begin
                        state_next = STATE_IDLE;
                    end
                end
            end
            default: state_next = STATE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_armleocpu_csr_exec.sv
// Directed bench for armleocpu_csr_exec with a tiny CSR file model:
// mscratch (0x340) read/write, 0xF11 read-only constant, everything else invalid.
module tb_armleocpu_csr_exec;
    import armleocpu_csr_exec_pkg::*;

    logic                     clk;
    logic                     rst;
    logic                     req_valid;
    logic                     req_ready;
    logic [2:0]               req_funct3;
    logic [11:0]              req_address;
    logic [31:0]              req_rs1_data;
    logic [4:0]               req_zimm;
    logic                     req_rs1_is_x0;
    logic                     req_rd_is_x0;
    logic                     kill;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [31:0]              rsp_rd_data;
    logic                     rsp_rd_write;
    logic                     rsp_invalid;
    logic [CSR_CMD_WIDTH-1:0] csr_cmd;
    logic [11:0]              csr_address;
    logic [31:0]              csr_writedata;
    logic [31:0]              csr_readdata;
    logic                     csr_invalid;

    logic [31:0] mscratch;
    int          n_assert;
    int          n_fail;

    armleocpu_csr_exec dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_funct3    (req_funct3),
        .req_address   (req_address),
        .req_rs1_data  (req_rs1_data),
        .req_zimm      (req_zimm),
        .req_rs1_is_x0 (req_rs1_is_x0),
        .req_rd_is_x0  (req_rd_is_x0),
        .kill          (kill),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rd_data   (rsp_rd_data),
        .rsp_rd_write  (rsp_rd_write),
        .rsp_invalid   (rsp_invalid),
        .csr_cmd       (csr_cmd),
        .csr_address   (csr_address),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .csr_invalid   (csr_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        csr_readdata = 32'd0;
        csr_invalid  = 1'b1;
        if (csr_address == 12'h340) begin
            csr_readdata = mscratch;
            csr_invalid  = 1'b0;
        end else if (csr_address == 12'hF11) begin
            csr_readdata = 32'h0A1AA1E0;
            csr_invalid  = (csr_cmd == CSR_CMD_WRITE) || (csr_cmd == CSR_CMD_READ_WRITE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mscratch <= 32'd0;
        end else if ((csr_cmd == CSR_CMD_WRITE || csr_cmd == CSR_CMD_READ_WRITE) && csr_address == 12'h340) begin
            mscratch <= csr_writedata;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one instruction, lets it be accepted on the next edge, then drops req_valid.
    task automatic apply_stimulus(input logic [2:0] funct3, input logic [11:0] address,
                                  input logic [31:0] rs1_data, input logic [4:0] zimm,
                                  input logic rs1_is_x0, input logic rd_is_x0);
        req_valid     = 1'b1;
        req_funct3    = funct3;
        req_address   = address;
        req_rs1_data  = rs1_data;
        req_zimm      = zimm;
        req_rs1_is_x0 = rs1_is_x0;
        req_rd_is_x0  = rd_is_x0;
        tick();
        req_valid     = 1'b0;
    endtask

    task automatic accept_response();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic write_mscratch(input logic [31:0] value);
        apply_stimulus(3'b001, 12'h340, value, 5'd0, 1'b0, 1'b1);
        tick();
        accept_response();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        check_output({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_output({tag, "_rsp_rd_data"}, rsp_rd_data, 32'd0);
        check_output({tag, "_rsp_rd_write"}, {31'd0, rsp_rd_write}, 32'd0);
        check_output({tag, "_rsp_invalid"}, {31'd0, rsp_invalid}, 32'd0);
        check_output({tag, "_csr_cmd"}, {28'd0, csr_cmd}, {28'd0, CSR_CMD_NONE});
        check_output({tag, "_csr_address"}, {20'd0, csr_address}, 32'd0);
        check_output({tag, "_csr_writedata"}, csr_writedata, 32'd0);
    endtask

    initial begin
        n_assert      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        req_valid     = 1'b0;
        req_funct3    = 3'd0;
        req_address   = 12'd0;
        req_rs1_data  = 32'd0;
        req_zimm      = 5'd0;
        req_rs1_is_x0 = 1'b0;
        req_rd_is_x0  = 1'b0;
        kill          = 1'b0;
        rsp_ready     = 1'b0;
        #3;
        check_reset_outputs("reset");
        tick();
        tick();
        rst = 1'b0;

        // CSRRW x0 preload: WRITE only, no rd write
        apply_stimulus(3'b001, 12'h340, 32'h0000_1234, 5'd0, 1'b0, 1'b1);
        check_output("rw_x0_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_WRITE});
        check_output("rw_x0_wdata", csr_writedata, 32'h0000_1234);
        tick();
        check_output("rw_x0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("rw_x0_rd_write", {31'd0, rsp_rd_write}, 32'd0);
        accept_response();

        // CSRRW mscratch, rs1=0xDEADBEEF
        apply_stimulus(3'b001, 12'h340, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0);
        check_output("rw_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_READ_WRITE});
        check_output("rw_addr", {20'd0, csr_address}, 32'h340);
        check_output("rw_wdata", csr_writedata, 32'hDEAD_BEEF);
        check_output("rw_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_output("rw_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("rw_rd_data", rsp_rd_data, 32'h0000_1234);
        check_output("rw_rd_write", {31'd0, rsp_rd_write}, 32'd1);
        check_output("rw_mscratch", mscratch, 32'hDEAD_BEEF);
        accept_response();

        // CSRRS mscratch=0x0F0 with rs1=0x00F
        write_mscratch(32'h0000_00F0);
        apply_stimulus(3'b010, 12'h340, 32'h0000_000F, 5'd0, 1'b0, 1'b0);
        check_output("rs_read_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_READ});
        tick();
        check_output("rs_write_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_WRITE});
        check_output("rs_wdata", csr_writedata, 32'h0000_00FF);
        check_output("rs_rsp_early", {31'd0, rsp_valid}, 32'd0);
        tick();
        check_output("rs_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("rs_rd_data", rsp_rd_data, 32'h0000_00F0);
        check_output("rs_mscratch", mscratch, 32'h0000_00FF);
        accept_response();

        // CSRRCI zimm=0x1F on 0xFF; rs1_data is garbage and must be ignored
        apply_stimulus(3'b111, 12'h340, 32'hFFFF_FFFF, 5'h1F, 1'b0, 1'b0);
        check_output("rci_read_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_READ});
        tick();
        check_output("rci_wdata", csr_writedata, 32'h0000_00E0);
        tick();
        check_output("rci_rd_data", rsp_rd_data, 32'h0000_00FF);
        accept_response();

        // CSRRS rs1=x0 on read-only 0xF11: READ only, response at T1
        apply_stimulus(3'b010, 12'hF11, 32'h0000_0000, 5'd0, 1'b1, 1'b0);
        check_output("ro_read_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_READ});
        tick();
        check_output("ro_no_write", {28'd0, csr_cmd}, {28'd0, CSR_CMD_NONE});
        check_output("ro_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("ro_invalid", {31'd0, rsp_invalid}, 32'd0);
        check_output("ro_rd_data", rsp_rd_data, 32'h0A1A_A1E0);
        check_output("ro_rd_write", {31'd0, rsp_rd_write}, 32'd1);
        accept_response();

        // CSRRW to read-only 0xF11
        apply_stimulus(3'b001, 12'hF11, 32'h1111_2222, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("rw_ro_invalid", {31'd0, rsp_invalid}, 32'd1);
        check_output("rw_ro_rd_write", {31'd0, rsp_rd_write}, 32'd0);
        check_output("rw_ro_rd_data", rsp_rd_data, 32'd0);
        accept_response();

        // Illegal funct3=100: no CSR command, response one cycle after accept
        apply_stimulus(3'b100, 12'h340, 32'h5555_5555, 5'd0, 1'b0, 1'b0);
        check_output("ill_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_NONE});
        check_output("ill_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check_output("ill_invalid", {31'd0, rsp_invalid}, 32'd1);
        accept_response();
        check_output("ill_mscratch", mscratch, 32'h0000_00E0);

        // Unimplemented address 0x7FF
        apply_stimulus(3'b010, 12'h7FF, 32'h0000_0000, 5'd0, 1'b1, 1'b0);
        tick();
        check_output("unimpl_invalid", {31'd0, rsp_invalid}, 32'd1);
        check_output("unimpl_rd_write", {31'd0, rsp_rd_write}, 32'd0);
        accept_response();

        // kill in IDLE gates req_ready and ignores the request
        req_valid  = 1'b1;
        req_funct3 = 3'b010;
        req_address = 12'h340;
        kill       = 1'b1;
        #1;
        check_output("kill_idle_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0;
        kill      = 1'b0;
        #1;
        check_output("kill_idle_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_NONE});
        check_output("kill_idle_rsp", {31'd0, rsp_valid}, 32'd0);

        // kill during WRITE of CSRRS rs1=0x00F on 0xE0
        apply_stimulus(3'b010, 12'h340, 32'h0000_000F, 5'd0, 1'b0, 1'b0);
        tick();
        kill = 1'b1;
        #1;
        check_output("kill_write_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_NONE});
        tick();
        kill = 1'b0;
        #1;
        check_output("kill_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("kill_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("kill_mscratch", mscratch, 32'h0000_00E0);

        // Response held stable while rsp_ready stays low
        apply_stimulus(3'b010, 12'h340, 32'h0000_0000, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check_output("hold_rd_data", rsp_rd_data, 32'h0000_00E0);
            check_output("hold_rd_write", {31'd0, rsp_rd_write}, 32'd1);
        end
        accept_response();
        check_output("hold_released", {31'd0, rsp_valid}, 32'd0);

        // Asynchronous reset during WRITE
        apply_stimulus(3'b010, 12'h340, 32'h0000_0001, 5'd0, 1'b0, 1'b0);
        tick();
        check_output("rst_pre_cmd", {28'd0, csr_cmd}, {28'd0, CSR_CMD_WRITE});
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        tick();
        rst = 1'b0;
        #1;
        check_output("rst_after_ready", {31'd0, req_ready}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
